// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit CPU: opcodes, control states, ALU ops.
package cpu_pkg;

   typedef enum logic [3:0] {
      OP_ALU  = 4'h0,
      OP_ADDI = 4'h1,
      OP_LW   = 4'h2,
      OP_SW   = 4'h3,
      OP_BEQ  = 4'h4,
      OP_JMP  = 4'h5,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } ctrl_state_e;

   localparam logic [2:0] ALU_ADD = 3'b000;

endpackage

// File: rtl/cpu_control_fsm_tmo.sv
// Memory-handshake timeout counter: expired marks the last waiting cycle.
module mem_timeout_ctr #(
   parameter int unsigned LIMIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [7:0] cnt_q, cnt_d;

   assign expired = enable && (cnt_q == 8'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable && !expired)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control FSM for the 8-bit CPU with shared memory port.
// Optional single-step fetch gating under CPU_SINGLE_STEP_EN.
module cpu_control_fsm
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       opcode,
   input  logic [2:0]       func,
   input  logic             alu_zero,
   input  logic             mem_ack,
   input  logic             step,
   output logic             ir_load,
   output logic             pc_inc,
   output logic             pc_load,
   output logic [2:0]       alu_op,
   output logic             alu_bsel,
   output logic             rf_we,
   output logic             rf_wsel,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_asel,
   output logic             halted,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] instret
);

   ctrl_state_e      state_q, state_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic             mem_asel_q, mem_asel_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             ack, retire, fetch_go;
   logic             tmo_clear, tmo_en, tmo_exp;

   assign ack    = mem_req_q && mem_ack;
   assign tmo_en = mem_req_q && !mem_ack;

   assign tmo_clear = (state_d != state_q) &&
                      ((state_d == S_FETCH) || (state_d == S_MEM));

   mem_timeout_ctr #(.LIMIT(MEM_TIMEOUT)) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmo_clear),
      .enable  (tmo_en),
      .expired (tmo_exp)
   );

`ifdef CPU_SINGLE_STEP_EN
   logic step_pend_q, step_pend_d;

   // Steps are only noticed while parked in FETCH.
   assign fetch_go = (state_q == S_FETCH) && (step_pend_q || step);

   always_comb begin
      step_pend_d = step_pend_q;
      if (state_q == S_FETCH)
         step_pend_d = (state_d == S_FETCH) && (step_pend_q || step);
   end

   always_ff @(posedge clk) begin
      if (rst)
         step_pend_q <= 1'b0;
      else
         step_pend_q <= step_pend_d;
   end
`else
   logic unused_step;
   assign unused_step = step;
   assign fetch_go    = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      retire    = 1'b0;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      alu_op    = ALU_ADD;
      alu_bsel  = 1'b0;
      rf_we     = 1'b0;
      rf_wsel   = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            if (ack) begin
               ir_load = 1'b1;
               pc_inc  = 1'b1;
               state_d = S_DECODE;
            end else if (tmo_exp) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_HALT: state_d = S_HALT;
               OP_ALU, OP_ADDI, OP_LW,
               OP_SW, OP_BEQ, OP_JMP: state_d = S_EXEC;
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_HALT;
               end
            endcase
         end
         S_EXEC: begin
            case (opcode)
               OP_ALU: begin
                  alu_op  = func;
                  state_d = S_WB;
               end
               OP_ADDI: begin
                  alu_bsel = 1'b1;
                  state_d  = S_WB;
               end
               OP_LW, OP_SW: begin
                  alu_bsel = 1'b1;
                  state_d  = S_MEM;
               end
               OP_BEQ: begin
                  pc_load = alu_zero;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               OP_JMP: begin
                  pc_load = 1'b1;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               default: state_d = S_HALT;
            endcase
         end
         S_MEM: begin
            if (ack) begin
               if (opcode == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end else if (tmo_exp) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            rf_wsel = (opcode == OP_LW);
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_HALT;
      endcase

      // Port controls are registered from the state being entered.
      mem_req_d  = (state_d == S_MEM) ||
                   ((state_d == S_FETCH) && fetch_go);
      mem_asel_d = (state_d == S_MEM);
      mem_we_d   = (state_d == S_MEM) && (opcode == OP_SW);
      instret_d  = instret_q + {{(CNT_W-1){1'b0}}, retire};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_asel_q <= 1'b0;
         illegal_q  <= 1'b0;
         bus_err_q  <= 1'b0;
         instret_q  <= '0;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_we_q   <= mem_we_d;
         mem_asel_q <= mem_asel_d;
         illegal_q  <= illegal_d;
         bus_err_q  <= bus_err_d;
         instret_q  <= instret_d;
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_we   = mem_we_q;
   assign mem_asel = mem_asel_q;
   assign halted   = (state_q == S_HALT);
   assign illegal  = illegal_q;
   assign bus_err  = bus_err_q;
   assign instret  = instret_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized bench for cpu_control_fsm against an instruction-level model.
module tb_cpu_control_fsm;

   localparam int MT = 15;
`ifdef CPU_SINGLE_STEP_EN
   localparam bit STEPB = 1'b1;
`else
   localparam bit STEPB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] opcode = '0;
   logic [2:0] func = '0;
   logic alu_zero = 1'b0, mem_ack = 1'b0, step = 1'b0;
   logic ir_load, pc_inc, pc_load, alu_bsel, rf_we, rf_wsel;
   logic mem_req, mem_we, mem_asel, halted, illegal, bus_err;
   logic [2:0] alu_op;
   logic [15:0] instret;

   cpu_control_fsm #(.MEM_TIMEOUT(MT), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func(func),
      .alu_zero(alu_zero), .mem_ack(mem_ack), .step(step),
      .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
      .alu_op(alu_op), .alu_bsel(alu_bsel), .rf_we(rf_we),
      .rf_wsel(rf_wsel), .mem_req(mem_req), .mem_we(mem_we),
      .mem_asel(mem_asel), .halted(halted), .illegal(illegal),
      .bus_err(bus_err), .instret(instret)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, pcl_n = 0;
   bit chk_en = 1'b0;
   logic e_ir, e_pci, e_pcl, e_bsel, e_we, e_wsel;
   logic e_req, e_mwe, e_asel, e_halt, e_ill, e_berr;
   logic [2:0] e_aop;
   logic [15:0] e_ins;
   logic [15:0] m_instret = '0;
   logic m_ill = 1'b0, m_berr = 1'b0;

   task automatic chk(input string n, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", n, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (pc_load) pcl_n++;
      if (chk_en) begin
         chk("ir_load", ir_load, e_ir);
         chk("pc_inc", pc_inc, e_pci);
         chk("pc_load", pc_load, e_pcl);
         chk("alu_op", alu_op, e_aop);
         chk("alu_bsel", alu_bsel, e_bsel);
         chk("rf_we", rf_we, e_we);
         chk("rf_wsel", rf_wsel, e_wsel);
         chk("mem_req", mem_req, e_req);
         chk("mem_we", mem_we, e_mwe);
         chk("mem_asel", mem_asel, e_asel);
         chk("halted", halted, e_halt);
         chk("illegal", illegal, e_ill);
         chk("bus_err", bus_err, e_berr);
         chk("instret", instret, e_ins);
      end
   end

   task automatic step_cyc();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   // Quiet defaults for one cycle; callers add what the phase implies.
   task automatic base();
      mem_ack  = 1'b0;
      alu_zero = 1'($urandom);
      step     = 1'($urandom);
      e_ir = 0; e_pci = 0; e_pcl = 0; e_aop = '0; e_bsel = 0;
      e_we = 0; e_wsel = 0; e_req = 0; e_mwe = 0; e_asel = 0;
      e_halt = 0; e_ill = m_ill; e_berr = m_berr; e_ins = m_instret;
   endtask

   task automatic halt_cycles(input int n);
      repeat (n) begin
         base();
         e_halt = 1'b1;
         step_cyc();
      end
   endtask

   task automatic apply_reset();
      chk_en = 1'b0;
      rst = 1'b1;
      mem_ack = 1'b0;
      step = 1'b0;
      step_cyc();
      m_instret = '0; m_ill = 1'b0; m_berr = 1'b0;
      base();
      step = 1'b0;
      chk_en = 1'b1;
      step_cyc();
      rst = 1'b0;
   endtask

   task automatic do_fetch(input bit idle, input int d, output bit ok);
      ok = 1'b1;
      if (STEPB) begin
         repeat ($urandom_range(0, 2)) begin
            base(); step = 1'b0; step_cyc();
         end
         base(); step = 1'b1; step_cyc();
      end else if (idle) begin
         base(); step_cyc();
      end
      for (int i = 0; i < d && i < MT; i++) begin
         base(); opcode = 4'($urandom); e_req = 1'b1; step_cyc();
      end
      if (d >= MT) begin
         m_berr = 1'b1; ok = 1'b0;
         halt_cycles(4);
         return;
      end
      base(); opcode = 4'($urandom); mem_ack = 1'b1;
      e_req = 1'b1; e_ir = 1'b1; e_pci = 1'b1;
      step_cyc();
   endtask

   task automatic do_instr(input logic [3:0] op, input logic [2:0] fn,
                           input logic z, input int dm, input bit rst_mem,
                           output bit ok);
      ok = 1'b1;
      base(); opcode = op; func = fn; step_cyc();
      if (op == 4'hF || op > 4'd5) begin
         if (op != 4'hF) m_ill = 1'b1;
         ok = 1'b0;
         halt_cycles(4);
         return;
      end
      base(); func = fn; alu_zero = z;
      case (op)
         4'd0: e_aop = fn;
         4'd1, 4'd2, 4'd3: e_bsel = 1'b1;
         4'd4: e_pcl = z;
         4'd5: e_pcl = 1'b1;
         default: ;
      endcase
      step_cyc();
      if (op == 4'd4 || op == 4'd5) begin
         m_instret++;
         return;
      end
      if (op == 4'd2 || op == 4'd3) begin
         for (int i = 0; i < dm && i < MT; i++) begin
            if (rst_mem && i == 2) begin
               apply_reset(); ok = 1'b0;
               return;
            end
            base(); e_req = 1; e_asel = 1; e_mwe = (op == 4'd3);
            step_cyc();
         end
         if (dm >= MT) begin
            m_berr = 1'b1; ok = 1'b0;
            halt_cycles(4);
            return;
         end
         base(); mem_ack = 1'b1;
         e_req = 1; e_asel = 1; e_mwe = (op == 4'd3);
         step_cyc();
         if (op == 4'd3) begin
            m_instret++;
            return;
         end
      end
      base(); e_we = 1'b1; e_wsel = (op == 4'd2); step_cyc();
      m_instret++;
   endtask

   function automatic int rdelay();
      int r = $urandom_range(0, 9);
      return (r == 9) ? 14 : r % 4;
   endfunction

   initial begin
      bit ok;
      int p0;
      @(posedge clk);
      #1;
      apply_reset();
      // ADDI right after reset, ack one cycle after request
      do_fetch(1, 1, ok);
      do_instr(4'd1, 3'd0, 0, 0, 0, ok);
      chk("t1_instret", instret, 1);
      // LW with a 3-cycle memory wait
      do_fetch(0, 1, ok);
      do_instr(4'd2, 3'd0, 0, 3, 0, ok);
      // BEQ taken then not taken
      p0 = pcl_n;
      do_fetch(0, 1, ok);
      do_instr(4'd4, 3'd0, 1, 0, 0, ok);
      do_fetch(0, 0, ok);
      do_instr(4'd4, 3'd0, 0, 0, 0, ok);
      chk("t3_pcl_pulses", pcl_n - p0, 1);
      chk("t3_instret", instret, 4);
      repeat (200) begin
         do_fetch(0, rdelay(), ok);
         do_instr(4'($urandom_range(0, 5)), 3'($urandom),
                  1'($urandom), rdelay(), 0, ok);
      end
      // reset in the middle of a data access
      do_fetch(0, 1, ok);
      do_instr(4'd2, 3'd0, 0, 6, 1, ok);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_instret", instret, 0);
      // ack on the last allowed waiting cycle
      do_fetch(1, MT - 1, ok);
      do_instr(4'd1, 3'd0, 0, 0, 0, ok);
      chk("ack15_bus_err", bus_err, 0);
      chk("ack15_instret", instret, 1);
      // illegal opcode 0x9
      do_fetch(0, 1, ok);
      do_instr(4'h9, 3'd0, 0, 0, 0, ok);
      chk("ill_flag", illegal, 1);
      chk("ill_halted", halted, 1);
      chk("ill_instret", instret, 1);
      chk("ill_mem_req", mem_req, 0);
      // fetch never acknowledged
      apply_reset();
      do_fetch(1, MT, ok);
      chk("tmo_bus_err", bus_err, 1);
      chk("tmo_halted", halted, 1);
      chk("tmo_mem_req", mem_req, 0);
      if (STEPB) begin
         apply_reset();
         repeat (3) begin
            do_fetch(1, 1, ok);
            do_instr(4'd0, 3'($urandom), 0, 0, 0, ok);
         end
         repeat (10) begin
            base(); step = 1'b0; step_cyc();
         end
         chk("step_instret", instret, 3);
      end
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
